apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

APB completer (slave) holding a word-addressed register-file memory, the responder end of the APB master in the bus subsystem. It accepts setup/access transfers, inserts a parameterised number of wait states, commits writes, returns read data, and flags PSLVERR for out-of-range addresses and reads of never-written locations. It also keeps a saturating error counter for debug visibility.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PADDR (word address, not byte address)
- DATA_WIDTH, 32, width of PWDATA/PRDATA
- DEPTH, 64, number of memory words; valid word addresses are 0..DEPTH-1
- WAIT_STATES, 1, wait cycles inserted per transfer (0..7)

Ports:
- PCLK  in  1  clock; all state updates on rising edge
- PRESET  in  1  asynchronous, active-high reset
- PSEL  in  1  slave select from master
- PENABLE  in  1  access phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  word address
- PWDATA  in  DATA_WIDTH  write data
- PREADY  out  1  transfer completes in a cycle where PREADY=1
- PRDATA  out  DATA_WIDTH  read data, valid only in the read completion cycle
- PSLVERR  out  1  error response, valid only in the completion cycle
- ERR_COUNT  out  8  number of error responses issued, saturates at 255

## Operation
- States: IDLE, ACCESS.
- IDLE: PREADY=0, PSLVERR=0, PRDATA=0. On a rising edge with PSEL=1 and PENABLE=0 (setup cycle): latch PADDR, PWRITE, PWDATA; load wait counter with WAIT_STATES; go to ACCESS.
- ACCESS: the counter decrements each edge while nonzero; PREADY=1 in exactly the cycle in which the counter is 0, otherwise 0.
- Completion cycle (ACCESS, PREADY=1, PSEL=1, PENABLE=1): the error flag is computed from the latched address/direction.
  - addr >= DEPTH: PSLVERR=1, no write, PRDATA=0.
  - read of a word whose valid bit is 0: PSLVERR=1, PRDATA=0.
  - write in range: mem[addr] <= latched PWDATA and valid[addr] <= 1 at the edge ending the cycle; PSLVERR=0.
  - read in range and valid: PRDATA=mem[addr]; PSLVERR=0.
  - On PSLVERR=1, ERR_COUNT increments at the edge ending the cycle, saturating at 255.
  - The next state is IDLE.
- Abort: if PSEL=0 at any edge while in ACCESS, return to IDLE with no write, no counter update, and PREADY=0 next cycle.
- The master holds PADDR, PWRITE, and PWDATA stable through access. The slave uses latched values only, so later changes have no effect.
- Write data for unwritten words is not readable. Only the valid bits reset; memory contents are not reset.
- A write followed by a read of the same address returns the new data. There is no forwarding hazard, because the transfers are at least 2 cycles apart.

## Timing
- Reset (asynchronous, immediate): state=IDLE, PREADY=0, PRDATA=0, PSLVERR=0, ERR_COUNT=0, all valid bits=0. A reset mid-transfer aborts it and no write occurs.
- Transfer length = 2 + WAIT_STATES cycles, from setup cycle T0 to completion cycle T1+WAIT_STATES.
- WAIT_STATES=0: PREADY=1 in T1, the first access cycle.
- Back-to-back: a setup cycle immediately following a completion cycle is accepted (IDLE sees PSEL=1, PENABLE=0). Sustained throughput is one transfer per 2+WAIT_STATES cycles.
- PRDATA and PSLVERR are nonzero only in completion cycles and return to 0 the next cycle.
- PREADY, PRDATA, and PSLVERR are registered outputs with no combinational path from inputs.

## Test plan
- Reset then read addr 45 (never written), WAIT_STATES=1 -> PREADY=1 in cycle T2, PSLVERR=1, PRDATA=0, ERR_COUNT=1.
- Write addr 22 data 35, then read addr 22 -> write completes with PSLVERR=0; read completion shows PRDATA=35, PSLVERR=0.
- Write addr 526 data 9 (DEPTH=64) -> PSLVERR=1, ERR_COUNT increments; a subsequent read of 526 gives PSLVERR=1 and PRDATA=0.
- Loop i=0..31: write addr i data i, then read back each -> PRDATA=i and no errors. Repeat with WAIT_STATES=0 and 3 -> completion at T1 and T4 respectively.
- Assert PRESET during the wait cycle of a write to addr 5 data 0xAA; then read addr 5 -> the write is dropped, the read gives PSLVERR=1, and all outputs are 0 during reset.
- Drop PSEL mid-access on a write to addr 7, then issue 300 error reads -> addr 7 stays unwritten and ERR_COUNT saturates at 255.

Source files
------------

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a word-addressed register file.
//   Accepts setup/access transfers, inserts WAIT_STATES wait cycles, commits
//   writes, returns read data and flags PSLVERR for out-of-range addresses
//   and for reads of words never written since reset.
// Ports:
//   PCLK, PRESET       clock, asynchronous active-high reset
//   PSEL, PENABLE      APB select / access-phase strobe
//   PWRITE, PADDR      direction and word address
//   PWDATA             write data
//   PREADY             high in the completion cycle (registered)
//   PRDATA, PSLVERR    read data / error response, nonzero only on completion
//   ERR_COUNT          saturating count of error responses issued
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic [7:0]            ERR_COUNT
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, state_n;
  logic [2:0]            cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic                  wr_q, wr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;

  logic                  done, commit;
  logic                  in_range_n;
  logic [IDX_W-1:0]      idx_n, idx_q;
  logic                  pready_n, pslverr_n;
  logic [DATA_WIDTH-1:0] prdata_n;

  assign idx_q  = addr_q[IDX_W-1:0];
  // PREADY is only ever high in ACCESS with the counter at zero.
  assign done   = (state == ACCESS) && PREADY && PSEL && PENABLE;
  assign commit = done && wr_q && (addr_q < ADDR_WIDTH'(DEPTH));

  // Next-state and next-latch logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    wr_n    = wr_q;
    wdata_n = wdata_q;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_n = ACCESS;
          cnt_n   = 3'(WAIT_STATES);
          addr_n  = PADDR;
          wr_n    = PWRITE;
          wdata_n = PWDATA;
        end
      end
      ACCESS: begin
        if (!PSEL)          state_n = IDLE;
        else if (done)      state_n = IDLE;
        else if (cnt != '0) cnt_n   = cnt - 3'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Response for the cycle being entered. Computed from the latch values
  // that will be held in that cycle, so outputs can be registered while the
  // WAIT_STATES=0 case still completes in the first access cycle.
  always_comb begin
    in_range_n = addr_n < ADDR_WIDTH'(DEPTH);
    idx_n      = addr_n[IDX_W-1:0];
    pready_n   = (state_n == ACCESS) && (cnt_n == '0);
    pslverr_n  = 1'b0;
    prdata_n   = '0;
    if (pready_n) begin
      if (!in_range_n) begin
        pslverr_n = 1'b1;
      end else if (!wr_n) begin
        if (valid[idx_n]) prdata_n  = mem[idx_n];
        else              pslverr_n = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt       <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      PSLVERR   <= 1'b0;
      ERR_COUNT <= '0;
      valid     <= '0;
    end else begin
      cnt     <= cnt_n;
      addr_q  <= addr_n;
      wr_q    <= wr_n;
      wdata_q <= wdata_n;
      PREADY  <= pready_n;
      PRDATA  <= prdata_n;
      PSLVERR <= pslverr_n;
      if (commit) valid[idx_q] <= 1'b1;
      if (done && PSLVERR && (ERR_COUNT != 8'hFF)) ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

  // Storage is deliberately not reset; the valid bits hide stale contents.
  always_ff @(posedge PCLK) begin
    if (commit) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;
  localparam int NK    = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic                   PCLK = 1'b0;
  logic                   PRESET;
  logic [NK-1:0]          psel, penable, pwrite, pready, pslverr;
  logic [NK-1:0][AW-1:0]  paddr;
  logic [NK-1:0][DW-1:0]  pwdata, prdata;
  logic [NK-1:0][7:0]     err_count;

  always #5 PCLK = ~PCLK;

  // Three instances differing only in wait states: k=0 -> 1, k=1 -> 0, k=2 -> 3.
  for (genvar g = 0; g < NK; g++) begin : g_dut
    apb_slave_mem #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .PSEL(psel[g]), .PENABLE(penable[g]), .PWRITE(pwrite[g]),
      .PADDR(paddr[g]), .PWDATA(pwdata[g]),
      .PREADY(pready[g]), .PRDATA(prdata[g]), .PSLVERR(pslverr[g]),
      .ERR_COUNT(err_count[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  // Reference model: plain memory, written flags, error tally.
  logic [DW-1:0] m_mem [NK][DEPTH];
  bit            m_val [NK][DEPTH];
  int            m_cnt [NK];

  typedef struct {
    int            k;
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
    int            cnt_before;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_cnt[k] = 0;
      for (int a = 0; a < DEPTH; a++) m_val[k][a] = 1'b0;
    end
  endtask

  // Monitor: pops an expectation whenever a DUT completes a transfer.
  exp_t mon_e;
  always @(negedge PCLK) begin
    if (!PRESET) begin
      for (int k = 0; k < NK; k++) begin
        if (pready[k]) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pready k=%0d cyc=%0d", k, cyc);
          end else begin
            mon_e = sbq.pop_front();
            if (mon_e.k != k || pslverr[k] !== mon_e.err || prdata[k] !== mon_e.rdata ||
                cyc != mon_e.cyc || err_count[k] !== 8'(mon_e.cnt_before)) begin
              errors++;
              $display("FAIL completion k=%0d got err=%0b rdata=%h cyc=%0d cnt=%0d want k=%0d err=%0b rdata=%h cyc=%0d cnt=%0d",
                       k, pslverr[k], prdata[k], cyc, err_count[k],
                       mon_e.k, mon_e.err, mon_e.rdata, mon_e.cyc, mon_e.cnt_before);
            end
          end
        end else begin
          checks++;
          if (pslverr[k] !== 1'b0 || prdata[k] !== '0) begin
            errors++;
            $display("FAIL idle_outputs k=%0d got pslverr=%0b prdata=%h want 0 0", k, pslverr[k], prdata[k]);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the completion edge so
  // the next call issues a back-to-back setup.
  task automatic xfer(input int k, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    int   n;
    int   a;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = data;
    e.k = k; e.cyc = cyc + 1 + ws_of(k); e.cnt_before = m_cnt[k]; e.err = 1'b0; e.rdata = '0;
    if (addr >= AW'(DEPTH)) begin
      e.err = 1'b1;
    end else begin
      a = int'(addr);
      if (wr) begin
        m_mem[k][a] = data; m_val[k][a] = 1'b1;
      end else if (m_val[k][a]) begin
        e.rdata = m_mem[k][a];
      end else begin
        e.err = 1'b1;
      end
    end
    if (e.err && m_cnt[k] < 255) m_cnt[k]++;
    sbq.push_back(e);
    @(posedge PCLK); #1;
    penable[k] = 1'b1;
    n = 0;
    while (!pready[k] && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    if (!pready[k]) begin
      checks++; errors++;
      $display("FAIL timeout k=%0d addr=%0d got no pready want pready within 20 cycles", k, addr);
    end
    @(posedge PCLK); #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
    checks++;
    if (err_count[k] !== 8'(m_cnt[k])) begin
      errors++;
      $display("FAIL err_count k=%0d got %0d want %0d", k, err_count[k], m_cnt[k]);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 || prdata[k] !== '0 || err_count[k] !== 8'd0) begin
        errors++;
        $display("FAIL %s k=%0d got pready=%0b pslverr=%0b prdata=%h cnt=%0d want all 0",
                 tag, k, pready[k], pslverr[k], prdata[k], err_count[k]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1;
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    chk_zero("reset_state");
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Unwritten read, write/read-back, out-of-range write and read.
    xfer(0, 1'b0, 45, '0);
    xfer(0, 1'b1, 22, 35);
    xfer(0, 1'b0, 22, '0);
    xfer(0, 1'b1, 526, 9);
    xfer(0, 1'b0, 526, '0);

    // Fill and read back on every wait-state variant.
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < 32; i++) xfer(k, 1'b1, AW'(i), DW'(i));
      for (int i = 0; i < 32; i++) xfer(k, 1'b0, AW'(i), '0);
    end

    // Reset during the wait cycle of a write to addr 5.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 5; pwdata[0] = 32'hAA;
    @(posedge PCLK); #1;
    penable[0] = 1'b1;
    #2 PRESET = 1'b1;
    #1 chk_zero("mid_reset");
    @(posedge PCLK); #1;
    chk_zero("held_reset");
    psel[0] = 1'b0; penable[0] = 1'b0;
    PRESET = 1'b0;
    model_reset();
    @(posedge PCLK); #1;
    xfer(0, 1'b0, 5, '0);

    // Abort a write to addr 7 by dropping PSEL in the wait cycle.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 7; pwdata[0] = 32'h1234;
    @(posedge PCLK); #1;
    penable[0] = 1'b1;
    @(negedge PCLK);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge PCLK); #1;
    checks++;
    if (pready[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_pready got %0b want 0", pready[0]);
    end
    @(posedge PCLK); #1;
    for (int i = 0; i < 300; i++) xfer(0, 1'b0, 7, '0);

    // Randomised traffic across all instances, including out-of-range addresses.
    for (int i = 0; i < 200; i++) begin
      xfer($urandom_range(0, NK - 1), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 79)), DW'($urandom));
    end

    repeat (3) @(posedge PCLK);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
    end
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (err_count[k] !== 8'(m_cnt[k])) begin
        errors++;
        $display("FAIL final_err_count k=%0d got %0d want %0d", k, err_count[k], m_cnt[k]);
      end
    end
    checks++;
    if (err_count[0] !== 8'd255) begin
      errors++;
      $display("FAIL saturation got %0d want 255", err_count[0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
